// File: rtl/hazard_detection_unit_pkg.sv
// Shared pipeline definitions: register-index width, hazard FSM encoding, NOP encoding.
package hazard_detection_unit_pkg;

    localparam int REG_W = 3;

    typedef enum logic {
        S_RUN      = 1'b0,
        S_MEM_WAIT = 1'b1
    } state_t;

    // Instruction word loaded into ID/EX when a bubble is inserted.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/hazard_detection_unit_compare.sv
// Load-use detector: flags a decode source that reads the destination of a load sitting in ID/EX.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module hazard_compare #(
    parameter int REG_W = 3
) (
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             rs_used,
    input  logic             rt_used,
    input  logic [REG_W-1:0] rd_idex,
    input  logic             mem_read_idex,
    input  logic             write_back_idex,
    output logic             load_use
);

    // Register 0 is an ordinary register here, so every index is compared.
    assign load_use = mem_read_idex & write_back_idex
                    & ((rs_used & (rs_id == rd_idex)) | (rt_used & (rt_id == rd_idex)));

endmodule

// File: rtl/hazard_detection_unit.sv
// Stall/bubble/flush control for hazards forwarding cannot cover: load-use, multi-cycle MEM, taken branch.
// Latency: controls combinational from inputs and state. Backpressure: it is the pipeline's stall source.
module hazard_detection_unit
    import hazard_detection_unit_pkg::*;
#(
    parameter int REG_W      = hazard_detection_unit_pkg::REG_W,
    parameter int MEM_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] i_rs_id,
    input  logic [REG_W-1:0] i_rt_id,
    input  logic             i_rs_used,
    input  logic             i_rt_used,
    input  logic [REG_W-1:0] i_rd_idex,
    input  logic             i_mem_read_idex,
    input  logic             i_write_back_idex,
    input  logic             i_mem_multi_start,
    input  logic             i_branch_taken,
    output logic             o_stall_pc,
    output logic             o_stall_ifid,
    output logic             o_bubble_idex,
    output logic             o_stall_back,
    output logic             o_flush_ifid,
    output logic             o_flush_idex,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_bubble_cnt
);

    localparam int WAIT_W = $clog2(MEM_CYCLES);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              load_use;

    hazard_compare #(.REG_W(REG_W)) u_compare (
        .rs_id           (i_rs_id),
        .rt_id           (i_rt_id),
        .rs_used         (i_rs_used),
        .rt_used         (i_rt_used),
        .rd_idex         (i_rd_idex),
        .mem_read_idex   (i_mem_read_idex),
        .write_back_idex (i_write_back_idex),
        .load_use        (load_use)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        o_stall_pc    = 1'b0;
        o_stall_ifid  = 1'b0;
        o_bubble_idex = 1'b0;
        o_stall_back  = 1'b0;
        o_flush_ifid  = 1'b0;
        o_flush_idex  = 1'b0;
        o_busy        = 1'b0;
        if (!rst) begin
            case (state)
                S_RUN: begin
                    if (i_mem_multi_start) begin
                        o_stall_pc   = 1'b1;
                        o_stall_ifid = 1'b1;
                        o_stall_back = 1'b1;
                        state_nxt    = S_MEM_WAIT;
                        wait_cnt_nxt = WAIT_W'(MEM_CYCLES - 2);
                    end else if (i_branch_taken) begin
                        o_flush_ifid = 1'b1;
                        o_flush_idex = 1'b1;
                    end else if (load_use) begin
                        o_stall_pc    = 1'b1;
                        o_stall_ifid  = 1'b1;
                        o_bubble_idex = 1'b1;
                    end
                end
                S_MEM_WAIT: begin
                    o_stall_pc   = 1'b1;
                    o_stall_ifid = 1'b1;
                    o_stall_back = 1'b1;
                    o_busy       = 1'b1;
                    // The start cycle already froze the pipe, so release one count early:
                    // the whole freeze then spans MEM_CYCLES-1 cycles including the start.
                    if (wait_cnt <= WAIT_W'(1)) begin
                        state_nxt = S_RUN;
                    end else begin
                        wait_cnt_nxt = wait_cnt - WAIT_W'(1);
                    end
                end
                default: state_nxt = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_bubble_cnt <= '0;
        end else if (o_stall_pc && (o_bubble_cnt != '1)) begin
            o_bubble_cnt <= o_bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit: vector table for single-cycle decode plus hand sequences.
module tb_hazard_detection_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rs_id = '0, rt_id = '0, rd_idex = '0;
    logic       rs_used = 1'b0, rt_used = 1'b0, mem_read = 1'b0, wb = 1'b0;
    logic       start = 1'b0, branch = 1'b0;
    logic       stall_pc, stall_ifid, bubble_idex, stall_back, flush_ifid, flush_idex, busy;
    logic [1:0] bubble_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt;

    // Expected-control encoding: {stall_pc, stall_ifid, bubble, stall_back, flush_ifid, flush_idex, busy}
    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_STALL = 7'b1110000;
    localparam logic [6:0] C_FLUSH = 7'b0000110;
    localparam logic [6:0] C_START = 7'b1101000;
    localparam logic [6:0] C_WAIT  = 7'b1101001;

    typedef struct packed {
        logic [2:0] rs;
        logic [2:0] rt;
        logic [2:0] rd;
        logic       rs_u;
        logic       rt_u;
        logic       mr;
        logic       wbk;
        logic       br;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs [9];

    hazard_detection_unit #(.REG_W(3), .MEM_CYCLES(3), .CNT_W(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_rs_id           (rs_id),
        .i_rt_id           (rt_id),
        .i_rs_used         (rs_used),
        .i_rt_used         (rt_used),
        .i_rd_idex         (rd_idex),
        .i_mem_read_idex   (mem_read),
        .i_write_back_idex (wb),
        .i_mem_multi_start (start),
        .i_branch_taken    (branch),
        .o_stall_pc        (stall_pc),
        .o_stall_ifid      (stall_ifid),
        .o_bubble_idex     (bubble_idex),
        .o_stall_back      (stall_back),
        .o_flush_ifid      (flush_ifid),
        .o_flush_idex      (flush_idex),
        .o_busy            (busy),
        .o_bubble_cnt      (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk_ctrl(input string nm, input logic [6:0] exp);
        logic [6:0] act;
        act = {stall_pc, stall_ifid, bubble_idex, stall_back, flush_ifid, flush_idex, busy};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: ctrl got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_cnt(input string nm, input int exp);
        total++;
        if (int'(bubble_cnt) != exp) begin
            bad++;
            $display("FAIL %s: bubble_cnt got %0d expected %0d", nm, bubble_cnt, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rs_id = v.rs; rt_id = v.rt; rd_idex = v.rd;
        rs_used = v.rs_u; rt_used = v.rt_u; mem_read = v.mr; wb = v.wbk; branch = v.br;
    endtask

    task automatic idle();
        rs_used = 1'b0; rt_used = 1'b0; mem_read = 1'b0; wb = 1'b0;
        start = 1'b0; branch = 1'b0;
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic load_use_on();
        rd_idex = 3'd3; rs_id = 3'd3; rs_used = 1'b1; mem_read = 1'b1; wb = 1'b1;
    endtask

    initial begin
        vecs[0] = '{3'd3, 3'd0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, C_STALL}; // rs load-use
        vecs[1] = '{3'd3, 3'd3, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_NONE};  // sources unused
        vecs[2] = '{3'd3, 3'd0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, C_NONE};  // index differs
        vecs[3] = '{3'd1, 3'd5, 3'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, C_STALL}; // rt load-use
        vecs[4] = '{3'd5, 3'd0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE};  // no write-back
        vecs[5] = '{3'd5, 3'd0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, C_NONE};  // not a load
        vecs[6] = '{3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, C_STALL}; // register 0 compares
        vecs[7] = '{3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_FLUSH}; // branch alone
        vecs[8] = '{3'd3, 3'd0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, C_FLUSH}; // branch beats load-use

        // Reset: controls held low even with a live load-use and start request.
        load_use_on();
        start = 1'b1;
        @(negedge clk);
        chk_ctrl("reset_ctrl", C_NONE);
        chk_cnt("reset_cnt", 0);
        idle();
        do_reset();

        // Table of single-cycle decode situations in S_RUN.
        exp_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            chk_ctrl($sformatf("vec%0d", i), vecs[i].exp);
            chk_cnt($sformatf("vec%0d_cnt", i), exp_cnt);
            if (vecs[i].exp[6] && exp_cnt < 3) exp_cnt++;
            next_cycle();
        end
        idle();

        // Branch and load-use together: flush only, counter does not move.
        do_reset();
        load_use_on();
        branch = 1'b1;
        @(negedge clk);
        chk_ctrl("br_lu_ctrl", C_FLUSH);
        next_cycle();
        idle();
        @(negedge clk);
        chk_ctrl("br_lu_after", C_NONE);
        chk_cnt("br_lu_cnt", 0);

        // Multi-cycle memory op, MEM_CYCLES=3: two frozen cycles, busy on the second.
        do_reset();
        start = 1'b1;
        @(negedge clk);
        chk_ctrl("mem_start", C_START);
        next_cycle();
        start = 1'b0;
        branch = 1'b1;
        load_use_on();
        @(negedge clk);
        chk_ctrl("mem_wait_br_ignored", C_WAIT);
        next_cycle();
        idle();
        branch = 1'b1;
        @(negedge clk);
        chk_ctrl("mem_release_branch", C_FLUSH);
        chk_cnt("mem_cnt", 2);
        next_cycle();
        idle();
        @(negedge clk);
        chk_ctrl("mem_idle", C_NONE);

        // Reset while waiting on memory.
        do_reset();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        chk_ctrl("rst_mid_pre", C_WAIT);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk_ctrl("rst_mid_during", C_NONE);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk_ctrl("rst_mid_after", C_NONE);
        chk_cnt("rst_mid_cnt", 0);

        // Saturation of the 2-bit counter over five separated load-use cycles.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            load_use_on();
            next_cycle();
            idle();
            @(negedge clk);
            chk_cnt($sformatf("sat%0d", k), (k + 1 > 3) ? 3 : k + 1);
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
